// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU take data_width RUN cycles plus one FIX cycle; MTHI/MTLO complete at the accepting edge.
module mult_div_unit #(
  parameter int unsigned data_width = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [data_width-1:0] operand_a,
  input  logic [data_width-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] hi,
  output logic [data_width-1:0] lo
);

  localparam int unsigned W    = data_width;
  localparam int unsigned CW   = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic             is_div_q, neg_q, rem_neg_q, div_zero_q, done_q;
  logic [W-1:0]     opnd_q, raw_a_q, rem_q;
  logic [2*W-1:0]   acc_q;
  logic [CW-1:0]    cnt_q;

  logic             accept, signed_op, a_neg, b_neg;
  logic [W-1:0]     a_mag, b_mag;

  logic [W:0]       mul_sum, div_shift, div_diff;
  logic             div_ge;
  logic [2*W-1:0]   acc_step;
  logic [W-1:0]     rem_step;

  logic [2*W-1:0]   prod;
  logic [W-1:0]     quot, remv, fix_hi, fix_lo;

  // Operand capture: signed ops (even op codes) work on magnitudes.
  always_comb begin
    accept    = (state_q == IDLE) && start && !op[2];
    signed_op = !op[0];
    a_neg     = signed_op && operand_a[W-1];
    b_neg     = signed_op && operand_b[W-1];
    a_mag     = a_neg ? -operand_a : operand_a;
    b_mag     = b_neg ? -operand_b : operand_b;
  end

  // One iteration. Multiply keeps {partial product, remaining multiplier} in acc_q;
  // divide keeps the dividend/quotient in acc_q's low half and the remainder in rem_q.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {rem_q, acc_q[W-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_ge    = !div_diff[W];
    if (is_div_q) begin
      acc_step = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
      rem_step = div_ge ? div_diff[W-1:0] : div_shift[W-1:0];
    end else begin
      acc_step = {mul_sum, acc_q[W-1:1]};
      rem_step = rem_q;
    end
  end

  always_comb begin
    prod   = neg_q ? -acc_q : acc_q;
    quot   = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    remv   = rem_neg_q ? -rem_q : rem_q;
    fix_hi = remv;
    fix_lo = quot;
    if (!is_div_q) begin
      {fix_hi, fix_lo} = prod;
    end else if (div_zero_q) begin
      fix_hi = raw_a_q;
      fix_lo = '1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      done_q     <= 1'b0;
      opnd_q     <= '0;
      raw_a_q    <= '0;
      rem_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
    end else begin
      done_q <= (state_q == FIX);
      if (accept) begin
        is_div_q   <= op[1];
        neg_q      <= a_neg ^ b_neg;
        rem_neg_q  <= a_neg;
        div_zero_q <= (operand_b == '0);
        raw_a_q    <= operand_a;
        rem_q      <= '0;
        cnt_q      <= '0;
        opnd_q     <= op[1] ? b_mag : a_mag;
        acc_q      <= op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
      end else if (state_q == RUN) begin
        acc_q <= acc_step;
        rem_q <= rem_step;
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hi <= '0;
      lo <= '0;
    end else if (state_q == FIX) begin
      hi <= fix_hi;
      lo <= fix_lo;
    end else if (state_q == IDLE && start) begin
      if (op == OP_MTHI) hi <= operand_a;
      if (op == OP_MTLO) lo <= operand_a;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases then random ops
// against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         reset, start;
  logic [2:0]   op;
  logic [W-1:0] operand_a, operand_b;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int unsigned  n_cmp = 0;
  int unsigned  n_bad = 0;
  logic [W-1:0] m_hi, m_lo;

  always #5 clock = ~clock;

  mult_div_unit #(.data_width(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns {hi, lo} for MULT/MULTU/DIV/DIVU.
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint p;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    case (o)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        return p;
      end
      3'd1: return {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called mid-cycle; the request is accepted on the next rising edge.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke_at, input int abort_at);
    logic [63:0] exp;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    start = 1'b1;
    op = o;
    operand_a = a;
    operand_b = b;
    @(posedge clock); #1;
    start = 1'b0;
    op = 3'($urandom);
    operand_a = $urandom;
    operand_b = $urandom;
    if (o == 3'd4) m_hi = a;
    if (o == 3'd5) m_lo = a;
    if (o[2]) begin
      check("idle_status", {busy, done}, 2'b00);
      check("idle_hilo", {hi, lo}, {m_hi, m_lo});
      return;
    end
    exp = model_result(o, a, b);
    check("accept_status", {busy, done}, 2'b10);
    for (int e = 1; e <= int'(W) + 1; e++) begin
      if (e == poke_at) begin
        start = 1'b1;
        op = 3'd3;
        operand_a = $urandom;
        operand_b = $urandom | 32'd1;
      end
      if (e == abort_at) begin
        #2;
        reset = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_status", {busy, done}, 2'b00);
        m_hi = '0;
        m_lo = '0;
        @(posedge clock); #1;
        check("abort_hold", {busy, done, hi, lo}, 66'd0);
        @(negedge clock);
        reset = 1'b1;
        return;
      end
      @(posedge clock); #1;
      if (e == poke_at) start = 1'b0;
      if (e <= int'(W)) begin
        check("run_status", {busy, done}, 2'b10);
        check("run_hold", {hi, lo}, {old_hi, old_lo});
      end else begin
        check("done_status", {busy, done}, 2'b01);
        check(o[1] ? "div_result" : "mul_result", {hi, lo}, exp);
      end
    end
    m_hi = exp[63:32];
    m_lo = exp[31:0];
  endtask

  initial begin
    logic [2:0]  o;
    logic [31:0] a, b;
    reset = 1'b0;
    start = 1'b0;
    op = '0;
    operand_a = '0;
    operand_b = '0;
    m_hi = '0;
    m_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_status", {busy, done}, 2'b00);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    run_op(3'd3, 32'd100, 32'd0, 0, 0);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, 0, 0);
    run_op(3'd4, 32'h0000_1234, 32'd9, 0, 0);
    run_op(3'd5, 32'hCAFE_F00D, 32'd9, 0, 0);
    run_op(3'd1, 32'd5, 32'd6, 10, 0);
    run_op(3'd6, 32'h1111_1111, 32'd3, 0, 0);
    run_op(3'd7, 32'h2222_2222, 32'd3, 0, 0);
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 15);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);

    for (int i = 0; i < 70; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clock); #1;
        check("gap_status", {busy, done}, 2'b00);
      end
      run_op(o, a, b, 0, 0);
    end

    @(posedge clock); #1;
    check("final_status", {busy, done}, 2'b00);
    check("final_hilo", {hi, lo}, {m_hi, m_lo});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit for the MIPS execute stage; it sits directly downstream of the register file and consumes its two read ports (`data_s1val` → `operand_a`, `data_s2val` → `operand_b`). It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers. MFHI and MFLO are served by the datapath reading `hi` and `lo` directly.

## Interface
- `data_width`, default 32: operand, HI and LO width; must be even and ≥ 4.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110 and 111 are reserved.
- `operand_a`  in  `data_width`  rs value (multiplicand, dividend, or MTHI/MTLO source).
- `operand_b`  in  `data_width`  rt value (multiplier or divisor).
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when a MULT/DIV result is written.
- `hi`  out  `data_width`  HI register.
- `lo`  out  `data_width`  LO register.

## Operation
- **States:**
  - IDLE
  - RUN: `data_width` iterations.
  - FIX: sign correction and write-back; always returns to IDLE.
- **IDLE with `start`=1:**
  - `op` and both operands are captured at that edge. Later input changes are ignored.
  - MULT, MULTU, DIV and DIVU go to RUN.
  - MTHI writes `hi` ← `operand_a` at that edge. MTLO writes `lo` ← `operand_a` at that edge. Both stay in IDLE and do not pulse `done`.
  - Reserved op codes produce no state change.
- **`start` outside IDLE:** ignored, with no queuing. Upstream must stall on `busy`.
- **Multiply:**
  - Unsigned shift-add over operand magnitudes, one multiplier bit per RUN cycle.
  - Signed ops take magnitudes at capture.
  - FIX negates the 2·`data_width` product when the operand signs differ.
  - {`hi`,`lo`} ← product.
- **Divide:**
  - Restoring division on magnitudes, one quotient bit per RUN cycle.
  - `lo` ← quotient, truncated toward zero.
  - `hi` ← remainder, carrying the sign of the dividend (signed ops).
- **Divide by zero** (any signedness): `lo` ← all ones, `hi` ← captured `operand_a` unchanged. RUN still takes the full iteration count.
- **Signed overflow:** the most negative value ÷ −1 gives `lo` ← most negative value and `hi` ← 0. No trap.
- **Internal widths:**
  - Product accumulator is 2·`data_width` bits.
  - Divider partial remainder is `data_width`+1 bits.
  - Iteration counter is ⌈log2(`data_width`)⌉+1 bits.
- **`hi`/`lo` update rules:** `hi` and `lo` change only at the FIX edge or on MTHI/MTLO. They hold their old values throughout RUN.

## Timing
- **Reset values:** `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE. Internal accumulator and counter are cleared.
- **Cycle numbering:** edge 0 is the accepting edge.
  - RUN occupies edges 1..`data_width`.
  - The FIX edge is `data_width`+1 and writes `hi`/`lo`.
- **Latency:** `data_width`+1 cycles from accept to result (33 for the default width).
- **`busy`:** 1 from after edge 0 through edge `data_width`. It is 0 in the cycle after the FIX edge.
- **`done`:** 1 for exactly the cycle after the FIX edge, coincident with new `hi`/`lo`.
- **Back-to-back:**
  - A new `start` is accepted on the edge that ends the `done` cycle, so `done` and accept may coincide.
  - Sustained throughput is one op per `data_width`+2 cycles.
- **MTHI/MTLO:** zero extra latency; the value is visible in the cycle after the accepting edge. `busy` stays 0.
- **Reset mid-operation:** the operation is aborted and no result is written. Reset values take effect immediately, without waiting for a clock edge.

## Test plan
- **MULTU** 0xFFFFFFFF × 0xFFFFFFFF → after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` is high for one cycle. `busy` is high for cycles 1–32.
- **MULT** −3 × 7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- **DIV** −7 ÷ 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- **DIV** 0x80000000 ÷ 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **DIVU** 100 ÷ 0 → `lo`=0xFFFFFFFF, `hi`=100.
- **MTHI** 0x1234 → `hi`=0x1234 next cycle with `busy`=0.
- **Start while busy:** start MULTU 5 × 6, then pulse `start` with DIVU at cycle 10 → the second request is ignored and `lo`=30 at cycle 33.
- **Reset mid-operation:** assert `reset`=0 at cycle 15 of a DIV → `hi`=`lo`=0 and `busy`=0 immediately, with no `done` pulse.
